rf_bitserial_sched: RTL and testbench
=====================================

Name: rf_bitserial_sched

Overview:
Sequencer for the bit-serial operand register file (VEC_LENGTH x DATA_WIDTH words, loaded by a single write enable).
- For each tile of a job, issues one on-chip SRAM read and pulses the register file write enable when the data returns.
- Then steps a bit-plane index 0..DATA_WIDTH-1 to the PE array under pe_ready backpressure, and repeats for num_tiles tiles.
- Sits between the top-level job controller and the register file / PE array.

Parameters:
DATA_WIDTH, 8, bits per operand word; number of bit-planes streamed per tile
ADDR_WIDTH, 10, SRAM row address width
TILE_WIDTH, 8, width of the tile-count field
BIT_IDX_W, $clog2(DATA_WIDTH), width of bit_idx (derived; must be >=1)

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-high reset
start  in  1  job start pulse; sampled only in IDLE
base_addr  in  ADDR_WIDTH  SRAM row of tile 0; latched on accepted start
num_tiles  in  TILE_WIDTH  tiles in job; latched on accepted start
sram_ren  out  1  SRAM read request, exactly one cycle per tile
sram_addr  out  ADDR_WIDTH  base_addr_q + tile_cnt (wraps mod 2^ADDR_WIDTH)
sram_rvalid  in  1  SRAM read data valid (latency >=1 cycle, variable)
rf_w_en  out  1  register-file write enable
bit_valid  out  1  bit_idx is valid for the PE array
bit_idx  out  BIT_IDX_W  current bit-plane, 0 = LSB
bit_msb  out  1  bit_valid && bit_idx == DATA_WIDTH-1 (sign plane)
pe_ready  in  1  PE array accepts current bit-plane
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at job end

Behaviour:
- Reset: state=IDLE; tile_cnt=0, bit_idx=0. sram_ren, rf_w_en, bit_valid, bit_msb, busy, done all 0; sram_addr=0. Reset overrides every other input in the same cycle.
- Reset mid-job aborts the job: IDLE on the next edge, no done pulse. An sram_rvalid arriving after reset is ignored.
- States: IDLE, FETCH, WAIT, STREAM, DONE. All outputs except rf_w_en are Moore, decoded from registered state/counters.
- IDLE:
  - start && num_tiles!=0: latch base_addr and num_tiles, tile_cnt=0, go to FETCH.
  - start && num_tiles==0: go to DONE (no SRAM traffic).
  - start in any other state: ignored.
- FETCH: sram_ren=1 for exactly one cycle, then WAIT unconditionally.
- WAIT:
  - rf_w_en = sram_rvalid (combinational); the register file captures on that edge.
  - On sram_rvalid: bit_idx=0, go to STREAM.
  - sram_rvalid in any other state: ignored, rf_w_en stays 0.
- STREAM:
  - bit_valid=1.
  - pe_ready=0: bit_idx holds.
  - pe_ready=1 && bit_idx<DATA_WIDTH-1: bit_idx+1.
  - pe_ready=1 && bit_idx==DATA_WIDTH-1, last tile (tile_cnt==num_tiles_q-1): go to DONE.
  - pe_ready=1 && bit_idx==DATA_WIDTH-1, not last tile: tile_cnt+1, go to FETCH.
- DONE: done=1, busy=1, for one cycle, then IDLE. A start seen in DONE is ignored.
- Timing: with read latency L and pe_ready held high, a tile takes 1 + L + DATA_WIDTH cycles. Job length = num_tiles*(DATA_WIDTH+1+L) + 1 (the DONE cycle).
- tile_cnt compares against the latched num_tiles_q; changes on num_tiles/base_addr after start have no effect.
- Non-power-of-two DATA_WIDTH is supported: bit_idx never exceeds DATA_WIDTH-1.

Decomposition:
- Package rf_sched_pkg holds:
  - state enum sched_state_e {IDLE, FETCH, WAIT, STREAM, DONE}
  - localparam BIT_IDX_W
- One natural sub-module, bitplane_counter:
  - Inputs: clear, advance (= pe_ready in STREAM).
  - Outputs: bit_idx, last (bit_idx==DATA_WIDTH-1).
  - Parameterised by DATA_WIDTH.
- The FSM and tile counter stay in rf_bitserial_sched.

Test Plan:
- Single tile, defaults: start with base_addr=0x010, num_tiles=1, L=1, pe_ready=1 -> sram_ren at cycle 1 with addr 0x010. rf_w_en at cycle 2. bit_idx 0..7 on cycles 3..10 with bit_msb only at 7. done at cycle 11. busy low at cycle 12.
- Three tiles, L=3: num_tiles=3, base_addr=0x3FE -> sram_addr sequence 0x3FE, 0x3FF, 0x000 (wrap). Exactly 3 rf_w_en pulses, 24 bit_valid cycles, done at cycle 3*(8+1+3)+1=37.
- Backpressure: pe_ready low on the bit_idx=2 cycle for 4 cycles -> bit_idx holds 2, bit_valid stays 1, no skipped or repeated plane. done delayed by exactly 4 cycles.
- num_tiles=0: start -> no sram_ren, no rf_w_en, done pulse the next cycle.
- Ignored inputs: start pulsed during STREAM -> no restart, latched params unchanged. sram_rvalid pulsed in IDLE or STREAM -> rf_w_en stays 0.
- Reset mid-job: assert reset in STREAM at bit_idx=5, tile 1 of 3 -> next cycle all outputs 0, state IDLE, no done. A late sram_rvalid produces no rf_w_en. A new start then runs a clean job from tile 0.

Source files
------------

// File: rtl/rf_bitserial_sched_pkg.sv
// Shared types and helpers for the bit-serial register-file sequencer.
package rf_sched_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    WAIT   = 3'd2,
    STREAM = 3'd3,
    DONE   = 3'd4
  } sched_state_e;

  // A one-plane operand still needs a 1-bit index.
  function automatic int bit_idx_width(input int data_width);
    return (data_width > 1) ? $clog2(data_width) : 1;
  endfunction

  localparam int DATA_WIDTH_DEF = 8;
  localparam int BIT_IDX_W      = bit_idx_width(DATA_WIDTH_DEF);

endpackage

// File: rtl/rf_bitserial_sched_if.sv
// Job, SRAM and PE-array signals of the sequencer; master is the sequencer side.
interface rf_bitserial_sched_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int TILE_WIDTH = 8,
  parameter int BIT_IDX_W  = rf_sched_pkg::bit_idx_width(8)
);

  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [TILE_WIDTH-1:0] num_tiles;
  logic                  sram_ren;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic                  sram_rvalid;
  logic                  rf_w_en;
  logic                  bit_valid;
  logic [BIT_IDX_W-1:0]  bit_idx;
  logic                  bit_msb;
  logic                  pe_ready;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, base_addr, num_tiles, sram_rvalid, pe_ready,
    output sram_ren, sram_addr, rf_w_en, bit_valid, bit_idx, bit_msb, busy, done
  );

  modport slave (
    output start, base_addr, num_tiles, sram_rvalid, pe_ready,
    input  sram_ren, sram_addr, rf_w_en, bit_valid, bit_idx, bit_msb, busy, done
  );

endinterface

// File: rtl/rf_bitserial_sched_bitplane_counter.sv
// Bit-plane index counter: 0..DATA_WIDTH-1, cleared per tile, advanced on PE accept.
module bitplane_counter #(
  parameter int DATA_WIDTH = 8,
  parameter int BIT_IDX_W  = rf_sched_pkg::bit_idx_width(DATA_WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 advance,
  output logic [BIT_IDX_W-1:0] bit_idx,
  output logic                 last
);

  localparam logic [BIT_IDX_W-1:0] LAST_IDX = BIT_IDX_W'(DATA_WIDTH - 1);

  assign last = (bit_idx == LAST_IDX);

  // Wrapping at the last plane keeps the index in range for non-power-of-two widths.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      bit_idx <= '0;
    end else if (advance) begin
      bit_idx <= last ? '0 : bit_idx + BIT_IDX_W'(1);
    end
  end

endmodule

// File: rtl/rf_bitserial_sched.sv
// Tile sequencer: one SRAM read per tile, register-file load, then bit-plane streaming.
module rf_bitserial_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int TILE_WIDTH = 8,
  parameter int BIT_IDX_W  = rf_sched_pkg::bit_idx_width(DATA_WIDTH)
) (
  input logic clk,
  input logic reset,
  rf_bitserial_sched_if.master bus
);

  import rf_sched_pkg::*;

  localparam logic [2:0] S_IDLE   = 3'(IDLE);
  localparam logic [2:0] S_FETCH  = 3'(FETCH);
  localparam logic [2:0] S_WAIT   = 3'(WAIT);
  localparam logic [2:0] S_STREAM = 3'(STREAM);
  localparam logic [2:0] S_DONE   = 3'(DONE);

  logic [2:0]            state_q;
  logic [TILE_WIDTH-1:0] tile_cnt_q;
  logic [TILE_WIDTH-1:0] num_tiles_q;
  logic [ADDR_WIDTH-1:0] base_addr_q;
  logic [BIT_IDX_W-1:0]  bit_idx;
  logic                  bit_last;
  logic                  last_tile;
  logic                  data_ret;
  logic                  plane_adv;

  assign last_tile = (tile_cnt_q == num_tiles_q - TILE_WIDTH'(1));
  assign data_ret  = (state_q == S_WAIT) && bus.sram_rvalid;
  assign plane_adv = (state_q == S_STREAM) && bus.pe_ready;

  bitplane_counter #(
    .DATA_WIDTH (DATA_WIDTH),
    .BIT_IDX_W  (BIT_IDX_W)
  ) u_bitplane_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (data_ret),
    .advance (plane_adv),
    .bit_idx (bit_idx),
    .last    (bit_last)
  );

  // Job parameters are captured only on an accepted start so later input changes are harmless.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tile_cnt_q  <= '0;
      num_tiles_q <= '0;
      base_addr_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.num_tiles != '0) begin
              base_addr_q <= bus.base_addr;
              num_tiles_q <= bus.num_tiles;
              tile_cnt_q  <= '0;
              state_q     <= S_FETCH;
            end else begin
              state_q <= S_DONE;
            end
          end
        end
        S_FETCH: state_q <= S_WAIT;
        S_WAIT: begin
          if (bus.sram_rvalid) begin
            state_q <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (bus.pe_ready && bit_last) begin
            if (last_tile) begin
              state_q <= S_DONE;
            end else begin
              tile_cnt_q <= tile_cnt_q + TILE_WIDTH'(1);
              state_q    <= S_FETCH;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // rf_w_en is the only combinational output; reset masks a read return landing in the same cycle.
  assign bus.sram_ren  = (state_q == S_FETCH);
  assign bus.sram_addr = base_addr_q + ADDR_WIDTH'(tile_cnt_q);
  assign bus.rf_w_en   = data_ret && !reset;
  assign bus.bit_valid = (state_q == S_STREAM);
  assign bus.bit_idx   = bit_idx;
  assign bus.bit_msb   = (state_q == S_STREAM) && bit_last;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);

endmodule

// File: tb/tb_rf_bitserial_sched.sv
// Scoreboard bench for rf_bitserial_sched: directed jobs, SRAM latency model, event monitor.
module tb_rf_bitserial_sched;

  localparam int DW  = 8;
  localparam int AW  = 10;
  localparam int TW  = 8;
  localparam int BW  = 3;
  localparam int BIG = 32'h7fff_ffff;

  localparam int K_REN  = 0;
  localparam int K_WEN  = 1;
  localparam int K_BIT  = 2;
  localparam int K_DONE = 3;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;

  typedef struct {
    int cyc;
    bit full;
  } ichk_t;

  logic clk = 1'b0;
  logic reset;
  logic model_rv = 1'b0;
  logic inj_rv = 1'b0;

  int   cyc = 0;
  int   lat = 1;
  int   pend = 0;
  int   st_from = BIG;
  int   st_len = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   exp_rd = 0;
  int   ichk_rd = 0;
  bit   end_req = 1'b0;
  bit   end_ack = 1'b0;

  ev_t   exp_q[$];
  ichk_t ichk_q[$];

  rf_bitserial_sched_if #(.ADDR_WIDTH(AW), .TILE_WIDTH(TW), .BIT_IDX_W(BW)) bus ();

  rf_bitserial_sched #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .TILE_WIDTH (TW),
    .BIT_IDX_W  (BW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.sram_rvalid = model_rv | inj_rv;

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // PE array: ready except inside the configured stall window.
  initial begin
    bus.pe_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.pe_ready = !(cyc >= st_from && cyc < st_from + st_len);
    end
  end

  // SRAM: read data returns lat cycles after the request cycle.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      model_rv = 1'b0;
      if (reset) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) model_rv = 1'b1;
        end
        if (bus.sram_ren) pend = lat;
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog act=timeout req=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input int kind, input int val);
    ev_t e;
    n_cmp++;
    if (exp_rd >= exp_q.size()) begin
      n_fail++;
      $display("[TB] FAIL unexpected_event act kind=%0d val=0x%0h cyc=%0d req=none", kind, val, cyc);
    end else begin
      e = exp_q[exp_rd];
      exp_rd++;
      if (e.kind != kind || e.val != val || e.cyc != cyc) begin
        n_fail++;
        $display("[TB] FAIL event act kind=%0d val=0x%0h cyc=%0d req kind=%0d val=0x%0h cyc=%0d",
                 kind, val, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask

  task automatic report_missed(input ev_t e);
    n_cmp++;
    n_fail++;
    $display("[TB] FAIL missed_event act=absent req kind=%0d val=0x%0h cyc=%0d", e.kind, e.val, e.cyc);
  endtask

  task automatic check_idle(input bit full);
    logic [5:0] flags;
    flags = {bus.sram_ren, bus.rf_w_en, bus.bit_valid, bus.bit_msb, bus.busy, bus.done};
    n_cmp++;
    if (flags != 6'b0) begin
      n_fail++;
      $display("[TB] FAIL idle_flags cyc=%0d act=%b req=000000", cyc, flags);
    end
    if (full) begin
      n_cmp++;
      if (bus.sram_addr != '0 || bus.bit_idx != '0) begin
        n_fail++;
        $display("[TB] FAIL reset_regs cyc=%0d act addr=0x%0h idx=%0d req addr=0x0 idx=0",
                 cyc, bus.sram_addr, bus.bit_idx);
      end
    end
  endtask

  // Monitor: expired expectations first, then whatever the DUT presents this cycle.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_rd < exp_q.size() && exp_q[exp_rd].cyc < cyc) begin
        report_missed(exp_q[exp_rd]);
        exp_rd++;
      end
      if (bus.sram_ren)  check_output(K_REN, int'(bus.sram_addr));
      if (bus.rf_w_en)   check_output(K_WEN, 0);
      if (bus.bit_valid) check_output(K_BIT, int'({bus.bit_msb, bus.bit_idx}));
      if (bus.done)      check_output(K_DONE, int'(bus.busy));
      if (ichk_rd < ichk_q.size() && ichk_q[ichk_rd].cyc == cyc) begin
        check_idle(ichk_q[ichk_rd].full);
        ichk_rd++;
      end
      if (end_req && !end_ack) begin
        while (exp_rd < exp_q.size()) begin
          report_missed(exp_q[exp_rd]);
          exp_rd++;
        end
        if (ichk_rd < ichk_q.size()) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL idle_checks act=%0d done req=%0d", ichk_rd, ichk_q.size());
        end
        end_ack = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push_ev(input int kind, input int val, input int c, input int stop);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = c;
    if (c <= stop) exp_q.push_back(e);
  endtask

  task automatic push_idle(input int c, input bit full);
    ichk_t k;
    k.cyc  = c;
    k.full = full;
    ichk_q.push_back(k);
  endtask

  // Expected trace of a job whose start is asserted during cycle s.
  task automatic push_job(input int s, input int base, input int n, input int l,
                          input int st_tile, input int st_bit, input int stl, input int stop);
    int c;
    int v;
    c = s + 1;
    for (int t = 0; t < n; t++) begin
      push_ev(K_REN, (base + t) & ((1 << AW) - 1), c, stop);
      c += l;
      push_ev(K_WEN, 0, c, stop);
      c++;
      for (int k = 0; k < DW; k++) begin
        v = ((k == DW - 1) ? (1 << BW) : 0) | k;
        if (t == st_tile && k == st_bit) begin
          for (int r = 0; r < stl; r++) begin
            push_ev(K_BIT, v, c, stop);
            c++;
          end
        end
        push_ev(K_BIT, v, c, stop);
        c++;
      end
    end
    push_ev(K_DONE, 1, c, stop);
  endtask

  task automatic apply_stimulus(input int base, input int n);
    bus.start     = 1'b1;
    bus.base_addr = AW'(base);
    bus.num_tiles = TW'(n);
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    int s;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.num_tiles = '0;
    repeat (3) tick();
    reset = 1'b0;
    push_idle(cyc, 1'b1);
    tick();
    tick();

    $display("[TB] single tile, latency 1");
    lat = 1;
    s = cyc;
    push_job(s, 'h010, 1, 1, -1, 0, 0, BIG);
    push_idle(s + 12, 1'b0);
    apply_stimulus('h010, 1);
    wait_until(s + 14);

    $display("[TB] three tiles, latency 3, address wrap");
    lat = 3;
    s = cyc;
    push_job(s, 'h3FE, 3, 3, -1, 0, 0, BIG);
    push_idle(s + 38, 1'b0);
    apply_stimulus('h3FE, 3);
    wait_until(s + 40);

    $display("[TB] backpressure on plane 2");
    lat = 1;
    s = cyc;
    st_from = s + 5;
    st_len  = 4;
    push_job(s, 'h020, 1, 1, 0, 2, 4, BIG);
    push_idle(s + 16, 1'b0);
    apply_stimulus('h020, 1);
    wait_until(s + 18);
    st_from = BIG;
    st_len  = 0;

    $display("[TB] zero-tile job");
    s = cyc;
    push_ev(K_DONE, 1, s + 1, BIG);
    push_idle(s + 2, 1'b0);
    apply_stimulus('h050, 0);
    wait_until(s + 4);

    $display("[TB] ignored start and stray read data");
    lat = 1;
    s = cyc;
    push_job(s, 'h040, 1, 1, -1, 0, 0, BIG);
    push_idle(s + 14, 1'b0);
    apply_stimulus('h040, 1);
    wait_until(s + 5);
    apply_stimulus('h100, 5);
    inj_rv = 1'b1;
    tick();
    inj_rv = 1'b0;
    wait_until(s + 13);
    inj_rv = 1'b1;
    tick();
    inj_rv = 1'b0;
    wait_until(s + 16);

    $display("[TB] reset mid-job then clean restart");
    lat = 1;
    s = cyc;
    push_job(s, 'h200, 3, 1, -1, 0, 0, s + 18);
    push_idle(s + 19, 1'b1);
    apply_stimulus('h200, 3);
    wait_until(s + 18);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    inj_rv = 1'b1;
    tick();
    inj_rv = 1'b0;
    wait_until(s + 22);
    s = cyc;
    push_job(s, 'h200, 1, 1, -1, 0, 0, BIG);
    push_idle(s + 12, 1'b0);
    apply_stimulus('h200, 1);
    wait_until(s + 14);

    end_req = 1'b1;
    for (int i = 0; i < 5 && !end_ack; i++) tick();
    if (!end_ack) begin
      $display("[TB] FAIL monitor_drain act=no_ack req=ack");
      $fatal(1, "[TB] monitor did not drain");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
